instr_issue: RTL and testbench



---
 rtl/instr_issue_pkg.sv | 32 +++
 rtl/instr_issue_if.sv | 29 ++
 rtl/instr_fifo.sv | 57 +++++
 rtl/instr_issue.sv | 122 ++++++++++++
 tb/tb_instr_issue.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_issue_pkg.sv
// Shared constants, issue FSM encoding and decode helpers for the instruction-issue front end.
package instr_issue_pkg;

    localparam int INSTR_W = 16;

    localparam logic [2:0] OPC_ALU = 3'b101;
    localparam logic [2:0] OPC_MOV = 3'b110;

    localparam logic [1:0] MOV_OP_REG = 2'b00;
    localparam logic [1:0] MOV_OP_IMM = 2'b10;

    localparam logic [2:0] NSEL_RN = 3'b100;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RM = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_EXEC  = 2'b10
    } issue_state_e;

    function automatic logic is_legal(input logic [INSTR_W-1:0] instr);
        logic legal;
        case (instr[15:13])
            OPC_ALU: legal = 1'b1;
            OPC_MOV: legal = (instr[12:11] == MOV_OP_REG) || (instr[12:11] == MOV_OP_IMM);
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/instr_issue_if.sv
// Producer and controller-facing signals of the issue front end; master is the issuing side.
interface instr_issue_if;
    import instr_issue_pkg::*;

    logic                in_valid;
    logic [INSTR_W-1:0]  in_instr;
    logic                in_ready;
    logic                w;
    logic                s;
    logic [2:0]          nsel;
    logic [2:0]          opcode;
    logic [1:0]          op;
    logic [2:0]          readnum;
    logic [2:0]          writenum;
    logic [15:0]         sximm5;
    logic [15:0]         sximm8;
    logic [1:0]          shift;
    logic [1:0]          ALUop;

    modport master (
        input  in_valid, in_instr, w, nsel,
        output in_ready, s, opcode, op, readnum, writenum, sximm5, sximm8, shift, ALUop
    );

    modport slave (
        output in_valid, in_instr, w, nsel,
        input  in_ready, s, opcode, op, readnum, writenum, sximm5, sximm8, shift, ALUop
    );
endinterface

// File: rtl/instr_fifo.sv
// Synchronous FIFO with head-of-queue read; no empty bypass, so a pushed word is visible next cycle.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == {CW{1'b0}});
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Storage, pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_issue.sv
// Issue front end: queues instruction words, screens illegal ones and starts the controller
// one instruction at a time with the s/w handshake, decoding the held IR for the datapath.
module instr_issue
    import instr_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    instr_issue_if.master              bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy,
    output logic                       err_illegal
);
    logic [INSTR_W-1:0] w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_head_legal;
    logic               w_pop;
    logic [2:0]         w_sel;

    issue_state_e       r_state;
    logic [INSTR_W-1:0] r_ir;
    logic               r_seen_low;
    logic               r_s;
    logic               r_err;
    logic               r_busy;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (bus.in_valid),
        .i_wdata (bus.in_instr),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    assign bus.in_ready = ~w_full;
    assign w_head_legal = is_legal(w_head);
    // Illegal heads are dropped without waiting for the controller.
    assign w_pop = (r_state == ST_IDLE) && !w_empty && (!w_head_legal || bus.w);

    // Issue FSM: owns IR, the start pulse, the discard pulse and the busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_ir       <= {INSTR_W{1'b0}};
            r_seen_low <= 1'b0;
            r_s        <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_s   <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty && !w_head_legal) begin
                        r_err <= 1'b1;
                    end else if (!w_empty && bus.w) begin
                        r_ir       <= w_head;
                        r_state    <= ST_START;
                        r_s        <= 1'b1;
                        r_busy     <= 1'b1;
                        r_seen_low <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_START: begin
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    // w must have dropped at least once before a high w means "done".
                    if (bus.w && r_seen_low) begin
                        r_state    <= ST_IDLE;
                        r_seen_low <= 1'b0;
                        r_busy     <= 1'b0;
                    end else if (!bus.w) begin
                        r_seen_low <= 1'b1;
                    end else begin
                        r_seen_low <= r_seen_low;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_seen_low <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    // Register-number mux; any non-one-hot select reads register 0.
    always_comb begin
        w_sel = 3'b000;
        case (bus.nsel)
            NSEL_RN: w_sel = r_ir[10:8];
            NSEL_RD: w_sel = r_ir[7:5];
            NSEL_RM: w_sel = r_ir[2:0];
            default: w_sel = 3'b000;
        endcase
    end

    assign bus.s        = r_s;
    assign err_illegal  = r_err;
    assign busy         = r_busy;
    assign bus.opcode   = r_ir[15:13];
    assign bus.op       = r_ir[12:11];
    assign bus.ALUop    = r_ir[12:11];
    assign bus.shift    = r_ir[4:3];
    assign bus.sximm5   = {{11{r_ir[4]}}, r_ir[4:0]};
    assign bus.sximm8   = {{8{r_ir[7]}}, r_ir[7:0]};
    assign bus.readnum  = w_sel;
    assign bus.writenum = w_sel;

endmodule

// File: tb/tb_instr_issue.sv
// Directed bench for instr_issue: a queue-based model checked every cycle plus hand-computed spot checks.
module tb_instr_issue;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] count;
    logic          busy;
    logic          err_illegal;

    instr_issue_if ifc();

    instr_issue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (ifc),
        .count       (count),
        .busy        (busy),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int s_cnt    = 0;
    int err_cnt  = 0;
    logic [15:0] issued[$];

    logic [15:0] mq[$];
    logic [15:0] m_ir      = 16'h0000;
    bit          m_flight  = 1'b0;
    bit          m_s_due   = 1'b0;
    bit          m_low     = 1'b0;
    bit          m_err_due = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [15:0] x);
        int opc;
        int op;
        opc = int'(x) >> 13;
        op  = (int'(x) >> 11) & 3;
        return (opc == 5) || (opc == 6 && (op == 0 || op == 2));
    endfunction

    function automatic logic [15:0] sext(input int v, input int bits);
        int r;
        r = v;
        if (r >= (1 << (bits - 1))) r = r - (1 << bits);
        return 16'(r);
    endfunction

    function automatic logic [2:0] pick(input logic [15:0] ir, input logic [2:0] ns);
        int v;
        v = int'(ir);
        case (ns)
            3'b100:  return 3'((v >> 8) & 7);
            3'b010:  return 3'((v >> 5) & 7);
            3'b001:  return 3'(v & 7);
            default: return 3'b000;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ir = 16'h0000; m_flight = 1'b0; m_s_due = 1'b0; m_low = 1'b0; m_err_due = 1'b0;
    endtask

    task automatic model_step();
        bit take;
        bit nxt_s;
        bit nxt_err;
        logic [15:0] dummy;
        take    = ifc.in_valid && (mq.size() < DEPTH);
        nxt_s   = 1'b0;
        nxt_err = 1'b0;
        if (m_flight) begin
            if (m_s_due) m_low = 1'b0;
            else if (ifc.w && m_low) begin m_flight = 1'b0; m_low = 1'b0; end
            else if (!ifc.w) m_low = 1'b1;
        end else if (mq.size() != 0) begin
            if (!legal(mq[0])) begin dummy = mq.pop_front(); nxt_err = 1'b1; end
            else if (ifc.w) begin m_ir = mq.pop_front(); m_flight = 1'b1; nxt_s = 1'b1; m_low = 1'b0; end
        end
        if (take) mq.push_back(ifc.in_instr);
        m_s_due   = nxt_s;
        m_err_due = nxt_err;
    endtask

    task automatic compare();
        chk("s",           32'(ifc.s),        32'(m_s_due));
        chk("err_illegal", 32'(err_illegal),  32'(m_err_due));
        chk("busy",        32'(busy),         32'(m_flight));
        chk("count",       32'(count),        32'(mq.size()));
        chk("in_ready",    32'(ifc.in_ready), 32'(mq.size() < DEPTH));
        chk("opcode",      32'(ifc.opcode),   32'(int'(m_ir) >> 13));
        chk("op",          32'(ifc.op),       32'((int'(m_ir) >> 11) & 3));
        chk("ALUop",       32'(ifc.ALUop),    32'((int'(m_ir) >> 11) & 3));
        chk("shift",       32'(ifc.shift),    32'((int'(m_ir) >> 3) & 3));
        chk("sximm5",      32'(ifc.sximm5),   32'(sext(int'(m_ir) & 31, 5)));
        chk("sximm8",      32'(ifc.sximm8),   32'(sext(int'(m_ir) & 255, 8)));
        chk("readnum",     32'(ifc.readnum),  32'(pick(m_ir, ifc.nsel)));
        chk("writenum",    32'(ifc.writenum), 32'(pick(m_ir, ifc.nsel)));
    endtask

    // Compare process: sample away from the rising edge, then advance the model with the held inputs.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) model_reset();
            compare();
            if (ifc.s === 1'b1) begin
                s_cnt++;
                if (ifc.nsel == 3'b100) issued.push_back({ifc.opcode, ifc.op, ifc.readnum, ifc.sximm8[7:0]});
            end
            if (err_illegal === 1'b1) err_cnt++;
            if (reset) model_step();
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] x);
        ifc.in_valid = 1'b1;
        ifc.in_instr = x;
        tick();
        ifc.in_valid = 1'b0;
    endtask

    task automatic finish_exec();
        ifc.w = 1'b0;
        tick();
        tick();
        ifc.w = 1'b1;
        tick();
    endtask

    task automatic serve(input int n);
        for (int k = 0; k < n; k++) begin
            int t;
            t = 0;
            while (ifc.s !== 1'b1 && t < 16) begin
                tick();
                t++;
            end
            chk("serve_start_seen", 32'(ifc.s), 32'(1'b1));
            finish_exec();
        end
    endtask

    logic [15:0] exp_issued [10];

    initial begin
        exp_issued = '{16'hD205, 16'hA14A, 16'hC043, 16'hBB1F, 16'hA0F0,
                       16'hD205, 16'hC043, 16'hBB1F, 16'hA14A, 16'hD205};
        reset        = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_instr = 16'h0000;
        ifc.w        = 1'b0;
        ifc.nsel     = 3'b100;
        #1;
        chk("rst_count",    32'(count),        32'd0);
        chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
        chk("rst_s",        32'(ifc.s),        32'd0);
        chk("rst_busy",     32'(busy),         32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        tick();

        // MOV R2,#5 from an empty FIFO with w high
        ifc.w = 1'b1;
        push_word(16'hD205);
        chk("mov_count_after_push", 32'(count), 32'd1);
        chk("mov_s_not_yet",        32'(ifc.s), 32'd0);
        tick();
        chk("mov_s",       32'(ifc.s),       32'd1);
        chk("mov_opcode",  32'(ifc.opcode),  32'(3'b110));
        chk("mov_op",      32'(ifc.op),      32'(2'b10));
        chk("mov_sximm8",  32'(ifc.sximm8),  32'(16'h0005));
        chk("mov_readnum", 32'(ifc.readnum), 32'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mov_no_second_s", 32'(ifc.s), 32'd0);
            chk("mov_busy_hold",   32'(busy),  32'd1);
        end
        chk("mov_s_total", 32'(s_cnt), 32'd1);
        finish_exec();
        chk("mov_idle", 32'(busy), 32'd0);

        // ADD then MOV queued; second start gated by the w low/high sequence
        push_word(16'hA14A);
        push_word(16'hC043);
        chk("add_s",       32'(ifc.s),       32'd1);
        chk("add_opcode",  32'(ifc.opcode),  32'(3'b101));
        chk("add_readnum", 32'(ifc.readnum), 32'd1);
        chk("add_count",   32'(count),       32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("add_no_s_w_high", 32'(ifc.s), 32'd0);
        end
        ifc.w = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        ifc.w = 1'b1;
        tick();
        chk("rise_plus1_s",    32'(ifc.s), 32'd0);
        chk("rise_plus1_busy", 32'(busy),  32'd0);
        tick();
        chk("rise_plus2_s",  32'(ifc.s),      32'd1);
        chk("movr_opcode",   32'(ifc.opcode), 32'(3'b110));
        chk("movr_op",       32'(ifc.op),     32'(2'b00));
        ifc.nsel = 3'b001;
        #1 chk("movr_rm", 32'(ifc.readnum), 32'd3);
        ifc.nsel = 3'b100;
        finish_exec();

        // illegal word followed by a legal one
        push_word(16'hE000);
        push_word(16'hBB1F);
        chk("ill_err",   32'(err_illegal), 32'd1);
        chk("ill_no_s",  32'(ifc.s),       32'd0);
        chk("ill_count", 32'(count),       32'd1);
        tick();
        chk("ill_next_s",      32'(ifc.s),      32'd1);
        chk("ill_err_cleared", 32'(err_illegal),32'd0);
        chk("alu_sximm5",      32'(ifc.sximm5), 32'(16'hFFFF));
        chk("alu_shift",       32'(ifc.shift),  32'(2'b11));
        chk("alu_op",          32'(ifc.ALUop),  32'(2'b11));
        finish_exec();
        chk("err_total", 32'(err_cnt), 32'd1);
        chk("s_total4",  32'(s_cnt),   32'd4);

        // fill past DEPTH with w low, then wrap through the pointers
        ifc.w = 1'b0;
        push_word(16'hA0F0);
        push_word(16'hD205);
        push_word(16'hC043);
        push_word(16'hBB1F);
        chk("full_count",    32'(count),        32'd4);
        chk("full_in_ready", 32'(ifc.in_ready), 32'd0);
        push_word(16'hA14A);
        chk("full_refused", 32'(count), 32'd4);
        ifc.w = 1'b1;
        tick();
        chk("fill_first_s", 32'(ifc.s),      32'd1);
        chk("fill_count3",  32'(count),      32'd3);
        chk("sximm5_neg",   32'(ifc.sximm5), 32'(16'hFFF0));
        chk("sximm8_neg",   32'(ifc.sximm8), 32'(16'hFFF0));
        ifc.nsel = 3'b011;
        #1;
        chk("nsel_bad_readnum",  32'(ifc.readnum),  32'd0);
        chk("nsel_bad_writenum", 32'(ifc.writenum), 32'd0);
        ifc.nsel = 3'b100;
        finish_exec();
        chk("fill_idle_count", 32'(count), 32'd3);
        push_word(16'hA14A);
        chk("pushpop_count", 32'(count), 32'd3);
        chk("pushpop_s",     32'(ifc.s), 32'd1);
        serve(4);
        chk("drained", 32'(count), 32'd0);

        // asynchronous reset in EXEC with three words buffered
        push_word(16'hD205);
        push_word(16'hA14A);
        push_word(16'hC043);
        push_word(16'hBB1F);
        chk("pre_rst_count", 32'(count), 32'd3);
        chk("pre_rst_busy",  32'(busy),  32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_count",    32'(count),        32'd0);
        chk("arst_s",        32'(ifc.s),        32'd0);
        chk("arst_busy",     32'(busy),         32'd0);
        chk("arst_in_ready", 32'(ifc.in_ready), 32'd1);
        chk("arst_opcode",   32'(ifc.opcode),   32'd0);
        chk("arst_sximm8",   32'(ifc.sximm8),   32'd0);
        chk("arst_readnum",  32'(ifc.readnum),  32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        tick();
        chk("post_rst_count", 32'(count), 32'd0);
        chk("post_rst_busy",  32'(busy),  32'd0);
        tick();

        chk("s_total", 32'(s_cnt), 32'd10);
        chk("issued_len", 32'(issued.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < issued.size()) chk("issue_order", 32'(issued[i]), 32'(exp_issued[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
